apb_rr_master: RTL

- Round-robin APB master that shares one APB slave (the team's 32-word APB RAM) between NUM_REQ local requesters.
- Each requester posts a single read or write command. The block arbitrates, runs the APB setup and access phases, waits for pready, and returns rdata/err to the winning requester.
- Sits between on-chip command sources (DMA, CPU shim, test sequencer) and the APB RAM port.

---
 rtl/apb_rr_pkg.sv | 9 +
 rtl/apb_rr_master_if.sv | 31 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/apb_rr_master.sv | 83 ++++++++
 4 files changed

// File: rtl/apb_rr_pkg.sv
// apb_rr_pkg: shared state type, width defaults and counter sizing for apb_rr_master
package apb_rr_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    function automatic int cnt_w(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction
endpackage

// File: rtl/apb_rr_master_if.sv
// apb_rr_master_if: requester command/response lanes plus the APB bus of apb_rr_master
interface apb_rr_master_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic rsp_err;
    logic psel;
    logic penable;
    logic pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic pready;
    logic pslverr;
    modport master (
        input req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant search starting at a registered pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input logic pclk,
    input logic preset,
    input logic [NUM_REQ-1:0] req,
    input logic advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0] idx,
    output logic any_req
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] j;
    // scan from the farthest slot back to ptr so the nearest requester wins last
    always_comb begin
        grant = '0;
        idx = '0;
        any_req = 1'b0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = j;
                any_req = 1'b1;
            end
        end
    end
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) ptr <= '0;
        else if (advance) ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one slave among NUM_REQ requesters
// APB_TIMEOUT_EN adds an access-phase watchdog of TIMEOUT_CYC cycles
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input logic pclk,
    input logic preset,
    apb_rr_master_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    state_t state, state_n;
    logic [NUM_REQ-1:0] grant, gnt_q;
    logic [IW-1:0] idx;
    logic any_req, accept, done, timeout;
    assign accept = state == IDLE && any_req;
    // completion is only judged once penable is on the bus
    assign done = state == ACCESS && bus.penable && (bus.pready || timeout);
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .pclk(pclk),
        .preset(preset),
        .req(bus.req_valid),
        .advance(accept),
        .grant(grant),
        .idx(idx),
        .any_req(any_req)
    );
`ifdef APB_TIMEOUT_EN
    localparam int CW = cnt_w(TIMEOUT_CYC);
    logic [CW-1:0] cnt;
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) cnt <= '0;
        else if (state == SETUP) cnt <= '0;
        else if (state == ACCESS && bus.penable && !bus.pready) cnt <= cnt + 1'b1;
    end
    assign timeout = bus.penable && !bus.pready && cnt == CW'(TIMEOUT_CYC - 1);
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (any_req ? SETUP : IDLE) :
                  state == SETUP ? ACCESS :
                  state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
    end
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err <= 1'b0;
            bus.psel <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite <= 1'b0;
            bus.paddr <= '0;
            bus.pwdata <= '0;
            gnt_q <= '0;
        end else begin
            bus.req_ready <= accept ? grant : '0;
            bus.rsp_valid <= done ? gnt_q : '0;
            bus.psel <= state == SETUP || (state == ACCESS && !done);
            bus.penable <= state == ACCESS && !done;
            if (accept) begin
                gnt_q <= grant;
                bus.pwrite <= bus.req_write[idx];
                bus.paddr <= bus.req_addr[idx*ADDR_W +: ADDR_W];
                bus.pwdata <= bus.req_wdata[idx*DATA_W +: DATA_W];
            end
            if (done) begin
                bus.rsp_rdata <= (bus.pwrite || !bus.pready) ? '0 : bus.prdata;
                bus.rsp_err <= bus.pready ? bus.pslverr : 1'b1;
            end
        end
    end
endmodule
